// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with a run-time loadable pattern,
// overlap/non-overlap modes, an input-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 in_valid,
    input  logic                 overlap,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
    input  logic                 cnt_clr,
    output logic                 z,
    output logic                 z_reg,
    output logic [CNT_W-1:0]     match_count
);

    localparam int                FILL_W   = $clog2(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PATTERN_W-1:0] pat_q,  pat_d;
    logic [PATTERN_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 z_reg_q;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;

    logic                 accept;
    logic                 full;
    logic [PATTERN_W-1:0] window;

    assign accept = in_valid & ~pat_load;
    assign full   = (fill_q == FILL_MAX);
    assign window = {hist_q, x};
    assign z      = accept & full & (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            // Non-overlap discards the whole match so the next one needs fresh bits.
            if (z && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PATTERN_W-2:0];
                fill_d = full ? fill_q : fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (z && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            z_reg_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_reg_q <= z;
            cnt_q   <= cnt_d;
        end
    end

    assign z_reg       = z_reg_q;
    assign match_count = cnt_q;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Mealy serial-pattern detector, the successor to the fixed 4-bit 1010 overlap detector in the sequential-circuits library. It adds a configurable pattern width, a pattern register loadable at run time, selectable overlap/non-overlap mode, an input-valid qualifier, a registered match flag and a saturating match counter. It sits on a 1-bit serial data stream and flags each cycle in which the most recent accepted bits equal the programmed pattern.

## Interface
- `PATTERN_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1010: pattern value loaded at reset. The MSB is the first bit received.
- `CNT_W`, default 8: width of the match counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `x` in 1: serial data bit. Sampled only when `in_valid` = 1.
- `in_valid` in 1: `x` is valid this cycle.
- `overlap` in 1: 1 selects overlapping detection; 0 selects non-overlapping detection.
- `pat_load` in 1: load `pat_in` into the pattern register and flush the detector history.
- `pat_in` in PATTERN_W: new pattern, MSB first.
- `cnt_clr` in 1: synchronous clear of `match_count`.
- `z` out 1: Mealy match output (combinational from the current state and inputs).
- `z_reg` out 1: `z` registered, one cycle later.
- `match_count` out CNT_W: number of matches, saturating.

## Operation
- State:
  - `pat_r` (PATTERN_W)
  - `hist` (PATTERN_W-1 bits): the last accepted bits, with `hist[0]` the newest.
  - `fill` (0..PATTERN_W-1): the number of valid bits held in `hist`.
  - `z_reg`
  - `match_count`
- Reset values:
  - `pat_r` = PATTERN.
  - `hist`, `fill`, `z_reg` and `match_count` = 0.
  - `z` = 0, because `fill` = 0.
- Match term:
  - `z` = `in_valid` & !`pat_load` & (`fill` == PATTERN_W-1) & ({`hist`, `x`} == `pat_r`).
- Accepted bit (`in_valid` = 1, `pat_load` = 0):
  - `hist` shifts left, taking `x` into bit 0.
  - `fill` increments and saturates at PATTERN_W-1.
- Match with `overlap` = 1:
  - History is retained, so the suffix of the match can start the next match. Example: 1010 gives a match every 2 bits on the stream 101010.
- Match with `overlap` = 0:
  - `fill` is forced to 0 and `hist` is cleared.
  - The next match needs PATTERN_W fresh bits.
- `overlap` is sampled on each accepted bit. It only affects the post-match update of that cycle. Changing it never corrupts the history.
- `in_valid` = 0: `hist` and `fill` hold, and `z` = 0.
- `pat_load` = 1:
  - `pat_r` <= `pat_in`; `hist` and `fill` are cleared.
  - Any `x` that is valid in the same cycle is discarded and `z` = 0.
  - `pat_load` has priority over `in_valid`.
  - `match_count` is not affected.
- `match_count`:
  - Increments on each cycle with `z` = 1.
  - Saturates at 2^CNT_W-1.
  - `cnt_clr` has priority: when `cnt_clr` = 1, the counter becomes 0 even if `z` = 1 in the same cycle.
- Reset mid-stream: all state returns immediately to the reset values, including a pattern that was loaded at run time being replaced by PATTERN.

## Timing
- `z` is valid in the same cycle as the completing bit, before the clock edge. It is combinational from `x`, `in_valid`, `pat_load` and state.
- `z_reg` follows `z` one cycle later. `match_count` updates at the same edge as `z_reg`.
- A loaded pattern takes effect from the cycle after `pat_load`. The earliest possible match is PATTERN_W accepted bits after the load.
- After `rst` deasserts, the first match needs PATTERN_W accepted bits.
- There is no combinational path from `x` to any registered output other than through the edge.

## Test plan
- Default parameters, `overlap` = 1, stream 1,0,1,0,1,0,1,0 with `in_valid` = 1 every cycle:
  - `z` = 1 on bits 4, 6 and 8.
  - `match_count` = 3 after the stream.
- Same stream with `overlap` = 0:
  - `z` = 1 on bits 4 and 8 only.
  - `match_count` = 2.
- Stream 1,0,1 with `in_valid` = 0 for 3 cycles, then 0:
  - `z` = 0 during the gap.
  - `z` = 1 on the final bit.
  - `z_reg` = 1 on the next cycle.
- `pat_load` with `pat_in` = 4'b1101 asserted in the same cycle as a valid bit that would have completed 1010:
  - `z` = 0 in that cycle.
  - The stream 1,1,0,1 then gives `z` = 1 on its 4th bit.
  - The stream 1,1,0,1,1,0,1 with overlap gives 2 matches.
- `CNT_W` = 2, overlap stream giving 5 matches:
  - `match_count` saturates at 3.
  - `cnt_clr` asserted in the same cycle as a match gives `match_count` = 0.
- Assert `rst` asynchronously mid-stream after loading a new pattern:
  - `hist`, `fill`, `z_reg` and `match_count` are 0 immediately, without waiting for a clock edge.
  - `pat_r` = 4'b1010.
  - A match requires 4 new bits.
